// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DBUSY,
    IBUSY,
    RESP
  } arb_state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 64;
  localparam int DEFAULT_STREAK_MAX     = 4;
  localparam logic [31:0] ERR_RDATA     = 32'h0;

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// arb_watchdog: counts stalled cycles of one memory transaction and flags
// the cycle in which the request has been outstanding TIMEOUT_CYCLES cycles.
module arb_watchdog
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != W'(TIMEOUT_CYCLES))) begin
      count <= count + W'(1);
    end
  end

  // Fires in the last permitted cycle so mem_req is high for exactly TIMEOUT_CYCLES cycles.
  assign expire = enable && (count == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requests onto one variable-latency memory port.
// Optional fetch anti-starvation guard: define ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int STREAK_MAX     = DEFAULT_STREAK_MAX
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        err,
  output logic        stall_f,
  output logic        stall_m,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  arb_state_t state, state_next;
  logic grant_d, grant_i, done_ack, done_to;
  logic busy, expire, starve;

  assign busy    = (state == DBUSY) || (state == IBUSY);
  assign stall_f = if_req & ~if_ready;
  assign stall_m = dm_req & ~dm_ready;

  arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (grant_d | grant_i),
    .enable (busy & ~(mem_req & mem_ack)),
    .expire (expire)
  );

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STREAK_MAX + 1);
  logic [SW-1:0] streak;

  assign starve = (streak == SW'(STREAK_MAX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak <= '0;
    end else if (grant_d) begin
      if (!if_req)
        streak <= '0;
      else if (!starve)
        streak <= streak + SW'(1);
    end else if (grant_i) begin
      streak <= '0;
    end
  end
`else
  assign starve = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant_d    = 1'b0;
    grant_i    = 1'b0;
    done_ack   = 1'b0;
    done_to    = 1'b0;
    case (state)
      IDLE: begin
        if (dm_req && !(if_req && starve)) begin
          grant_d    = 1'b1;
          state_next = DBUSY;
        end else if (if_req) begin
          grant_i    = 1'b1;
          state_next = IBUSY;
        end
      end
      DBUSY, IBUSY: begin
        if (mem_req && mem_ack) begin
          done_ack   = 1'b1;
          state_next = RESP;
        end else if (expire) begin
          done_to    = 1'b1;
          state_next = RESP;
        end
      end
      // Requests still held during the ready cycle must not re-issue.
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      err       <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      err      <= 1'b0;
      if (grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
      end else if (grant_i) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= if_addr;
      end
      if (done_ack || done_to) begin
        mem_req <= 1'b0;
        err     <= done_to;
        if (state == IBUSY)
          if_ready <= 1'b1;
        else
          dm_ready <= 1'b1;
      end
      if (done_ack && (state == IBUSY))
        if_rdata <= mem_rdata;
      if (done_ack && (state == DBUSY) && !mem_we)
        dm_rdata <= mem_rdata;
      if (done_to) begin
        if (state == IBUSY)
          if_rdata <= ERR_RDATA;
        else
          dm_rdata <= ERR_RDATA;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (optionally with ARB_STARVE_GUARD_EN).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        err;
  logic        stall_f;
  logic        stall_m;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.TIMEOUT_CYCLES(64), .STREAK_MAX(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ready  (dm_ready),
    .err       (err),
    .stall_f   (stall_f),
    .stall_m   (stall_m),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  // Every comparison funnels through here so the summary counts stay honest.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Bounded wait for the arbiter to issue; returns at the first negedge with mem_req high.
  task automatic waitReq(input string tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) return;
    end
    checkOutput({tag, "_issue_timeout"}, 32'(mem_req), 32'd1);
  endtask

  // Ack after 'delay' further cycles of mem_req; returns at the negedge of the ready cycle.
  task automatic applyStimulus(input int delay, input logic [31:0] data);
    repeat (delay) @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = data;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
  endtask

  initial begin
    int cycles;
    reset = 1'b1; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0;
    dm_addr = 0; dm_wdata = 0; mem_rdata = 0; mem_ack = 0;
    repeat (2) @(negedge clk);
    checkOutput("rst_mem_req",  32'(mem_req),  32'd0);
    checkOutput("rst_mem_addr", mem_addr,      32'h0);
    checkOutput("rst_if_ready", 32'(if_ready), 32'd0);
    checkOutput("rst_dm_ready", 32'(dm_ready), 32'd0);
    checkOutput("rst_err",      32'(err),      32'd0);
    checkOutput("rst_if_rdata", if_rdata,      32'h0);
    checkOutput("rst_dm_rdata", dm_rdata,      32'h0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] fetch only");
    if_req = 1; if_addr = 32'h40;
    waitReq("f1");
    checkOutput("f1_addr",    mem_addr,      32'h40);
    checkOutput("f1_we",      32'(mem_we),   32'd0);
    checkOutput("f1_stall",   32'(stall_f),  32'd1);
    applyStimulus(2, 32'h8C820004);
    checkOutput("f1_ready",   32'(if_ready), 32'd1);
    checkOutput("f1_rdata",   if_rdata,      32'h8C820004);
    checkOutput("f1_err",     32'(err),      32'd0);
    checkOutput("f1_mem_req", 32'(mem_req),  32'd0);
    checkOutput("f1_unstall", 32'(stall_f),  32'd0);
    if_req = 0;
    @(negedge clk);
    checkOutput("f1_pulse",   32'(if_ready), 32'd0);

    $display("[TB] simultaneous fetch and load");
    if_req = 1; if_addr = 32'h40; dm_req = 1; dm_we = 0; dm_addr = 32'h100;
    waitReq("c1");
    checkOutput("c1_data_first", mem_addr,     32'h100);
    checkOutput("c1_stall_f",    32'(stall_f), 32'd1);
    checkOutput("c1_stall_m",    32'(stall_m), 32'd1);
    applyStimulus(1, 32'h11112222);
    checkOutput("c1_dm_ready",   32'(dm_ready), 32'd1);
    checkOutput("c1_dm_rdata",   dm_rdata,      32'h11112222);
    checkOutput("c1_if_ready",   32'(if_ready), 32'd0);
    dm_req = 0;
    @(negedge clk);
    checkOutput("c1_no_dup",     32'(mem_req),  32'd0);
    waitReq("c2");
    checkOutput("c2_fetch_addr", mem_addr,      32'h40);
    checkOutput("c2_fetch_we",   32'(mem_we),   32'd0);
    applyStimulus(0, 32'h0BADC0DE);
    checkOutput("c2_if_ready",   32'(if_ready), 32'd1);
    checkOutput("c2_if_rdata",   if_rdata,      32'h0BADC0DE);
    checkOutput("c2_dm_ready",   32'(dm_ready), 32'd0);
    checkOutput("c2_dm_hold",    dm_rdata,      32'h11112222);
    if_req = 0;
    @(negedge clk);

    $display("[TB] store");
    dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'hCAFEF00D;
    waitReq("s1");
    checkOutput("s1_addr",     mem_addr,      32'h200);
    checkOutput("s1_we",       32'(mem_we),   32'd1);
    checkOutput("s1_wdata",    mem_wdata,     32'hCAFEF00D);
    applyStimulus(0, 32'hDEADBEEF);
    checkOutput("s1_ready",    32'(dm_ready), 32'd1);
    checkOutput("s1_rdata",    dm_rdata,      32'h11112222);
    checkOutput("s1_mem_req",  32'(mem_req),  32'd0);
    checkOutput("s1_wdata_hold", mem_wdata,   32'hCAFEF00D);
    @(negedge clk);
    checkOutput("s1_no_reissue", 32'(mem_req), 32'd0);
    dm_req = 0; dm_we = 0;
    @(negedge clk);

    $display("[TB] watchdog timeout");
    dm_req = 1; dm_we = 0; dm_addr = 32'h300;
    waitReq("t1");
    cycles = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!mem_req) break;
      cycles++;
    end
    checkOutput("t1_req_cycles", 32'(cycles),   32'd64);
    checkOutput("t1_ready",      32'(dm_ready), 32'd1);
    checkOutput("t1_err",        32'(err),      32'd1);
    checkOutput("t1_rdata",      dm_rdata,      32'h0);
    dm_req = 0;
    @(negedge clk);
    checkOutput("t1_err_pulse",  32'(err),      32'd0);
    checkOutput("t1_ready_pulse", 32'(dm_ready), 32'd0);

    $display("[TB] reset during fetch");
    if_req = 1; if_addr = 32'h44;
    waitReq("r1");
    #2 reset = 1'b1;
    #1 checkOutput("r1_async_drop", 32'(mem_req), 32'd0);
    @(negedge clk);
    checkOutput("r1_no_ready",   32'(if_ready), 32'd0);
    reset = 1'b0;
    waitReq("r2");
    checkOutput("r2_addr",       mem_addr,      32'h44);
    applyStimulus(0, 32'h12345678);
    checkOutput("r2_ready",      32'(if_ready), 32'd1);
    checkOutput("r2_rdata",      if_rdata,      32'h12345678);
    if_req = 0;
    @(negedge clk);

    $display("[TB] sustained data traffic with fetch pending");
    if_req = 1; if_addr = 32'h40; dm_req = 1; dm_we = 0; dm_addr = 32'h100;
    for (int g = 0; g < 4; g++) begin
      waitReq("g_data");
      checkOutput($sformatf("g%0d_data", g), mem_addr, 32'h100);
      applyStimulus(0, 32'(g));
    end
    waitReq("g_fifth");
`ifdef ARB_STARVE_GUARD_EN
    checkOutput("g4_guard_fetch", mem_addr, 32'h40);
`else
    checkOutput("g4_strict_data", mem_addr, 32'h100);
`endif
    applyStimulus(0, 32'h55);
    if_req = 0; dm_req = 0;
    repeat (2) @(negedge clk);
    checkOutput("end_idle", 32'(mem_req), 32'd0);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] global timeout");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage pipeline. It serialises requests and runs a per-transaction handshake with a variable-latency memory. It drives stall requests back to the hazard logic while a requester waits. A per-transaction watchdog returns an error response if memory never acknowledges.

Parameters:
TIMEOUT_CYCLES, 64, max cycles mem_req may stay high without mem_ack before abort (>=2)
STREAK_MAX, 4, max consecutive data grants while if_req pending (used only with optional feature)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
if_req  input  1  fetch read request, level, held until if_ready
if_addr  input  32  fetch byte address, stable while if_req
if_rdata  output  32  fetched instruction, valid when if_ready
if_ready  output  1  one-cycle completion pulse for fetch
dm_req  input  1  data request, level, held until dm_ready
dm_we  input  1  1=store, 0=load, stable while dm_req
dm_addr  input  32  data byte address
dm_wdata  input  32  store data
dm_rdata  output  32  load data, valid when dm_ready
dm_ready  output  1  one-cycle completion pulse for data
err  output  1  pulses with if_ready/dm_ready when transaction timed out
stall_f  output  1  if_req & ~if_ready (combinational)
stall_m  output  1  dm_req & ~dm_ready (combinational)
mem_req  output  1  registered request to memory
mem_we  output  1  registered write enable
mem_addr  output  32  registered address
mem_wdata  output  32  registered write data
mem_rdata  input  32  memory read data, valid with mem_ack
mem_ack  input  1  memory completion, sampled only while mem_req=1

Behaviour:
- FSM states: IDLE, DBUSY, IBUSY, RESP.
- Reset (async) values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ready=0, dm_ready=0, err=0, if_rdata=0, dm_rdata=0, watchdog=0.
- IDLE, dm_req=1 -> DBUSY. Latch dm_addr/dm_we/dm_wdata into mem_*; mem_req=1 from next cycle.
- IDLE, dm_req=0 and if_req=1 -> IBUSY. Latch if_addr, mem_we=0.
- IDLE, both requests -> data wins. The older instruction in the pipe has priority.
- xBUSY, mem_ack=1 -> RESP. Next cycle: mem_req=0, matching ready=1 for exactly one cycle.
  - Read: matching rdata register <= mem_rdata.
  - Store: dm_rdata holds its previous value.
- xBUSY, no ack -> watchdog increments; watchdog width = $clog2(TIMEOUT_CYCLES+1).
- Watchdog reaching TIMEOUT_CYCLES -> abort to RESP. mem_req=0, ready=1, err=1, rdata register <= 32'h0.
- RESP -> IDLE unconditionally.
  - Requests are ignored in RESP: the requester still holds req during its ready cycle.
  - Prevents a duplicate issue.
- Watchdog clears on entry to any BUSY state.
- Minimum latency: req sampled in IDLE at cycle N, mem_req high N+1, ack at N+1, ready at N+2. Back-to-back transaction issues at N+3.
- mem_ack while mem_req=0 is ignored.
- mem_* outputs hold their value after a transaction, with mem_req=0.
- Reset mid-transaction: immediate return to IDLE, mem_req drops asynchronously, transaction discarded, no ready pulse.
- A requester dropping req before ready is a protocol violation. The transaction still completes and ready still pulses.

Optional Feature:
- Macro ARB_STARVE_GUARD_EN.
- Defined: a streak counter (0..STREAK_MAX) counts data grants made while if_req=1.
  - At IDLE with both requests and streak==STREAK_MAX, fetch is granted instead and the streak clears.
  - Streak also clears on any fetch grant, or on a data grant with if_req=0.
- Undefined: strict data priority, no streak counter, fetch can starve.

Decomposition:
- Package mips_mem_pkg holds:
  - arb_state_t enum (IDLE, DBUSY, IBUSY, RESP)
  - default TIMEOUT_CYCLES
  - constant ERR_RDATA=32'h0
- One natural sub-module, arb_watchdog: clear/enable inputs, expire output, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Fetch only, if_addr=0x40, memory acks 3 cycles after mem_req, mem_rdata=0x8C820004 -> mem_addr=0x40, if_ready one pulse with if_rdata=0x8C820004, stall_f high until ready.
- if_req and dm_req (load 0x100) raised same cycle -> data issued first, dm_ready pulses, then mem_addr=0x40 fetch issued, if_ready pulses later. No duplicate issue.
- Store dm_addr=0x200, wdata=0xCAFEF00D, ack at 1 cycle -> mem_we=1, mem_wdata=0xCAFEF00D, dm_ready at N+2, dm_rdata unchanged, next transaction no earlier than N+3.
- Memory never acks -> after 64 cycles mem_req=0, dm_ready=1, err=1, dm_rdata=0. FSM back to IDLE.
- reset asserted while IBUSY -> mem_req=0 without waiting for a clock edge, no if_ready. After release, fetch reissues normally.
- With ARB_STARVE_GUARD_EN, STREAK_MAX=4, dm_req held continuously with if_req pending -> fetch granted after the 4th data grant.
